// File: rtl/seg7_scan_ctrl.sv
// seg7_scan_ctrl
//   Time-multiplexed seven-segment display controller. Scans NUM_DIGITS
//   digits, spending CLK_DIV clk cycles on each digit. Every digit shows the
//   hex value (0-F) of its nibble in data, plus an optional decimal point.
//
//   Scan state:
//   - div_cnt: the cycle position within the current digit slot.
//   - idx: the digit being shown.
//   - Shadow copies of data/dp_in/blank, so the digits shown are always one
//     consistent snapshot of the inputs.
//
//   The shadows load on the first enabled cycle after reset. After that they
//   load only when the scan wraps from the last digit back to digit 0, so an
//   input change never reaches the pins part-way through a frame.
//
//   For the first GUARD cycles of each slot every anode is off. This gives
//   the previous digit's drivers time to turn off before the next digit
//   lights, which prevents ghosting.
//
//   All outputs are registered. They show the scan state of the previous
//   cycle.
//
// Ports
//   clk    system clock
//   rst    synchronous reset, active-high; takes priority over en
//   en     scan enable; while low the scan position is frozen and the
//          anodes are off
//   data   nibble k is the hex value of digit k (digit 0 in the LSBs)
//   dp_in  bit k lights the decimal point of digit k
//   blank  bit k forces digit k dark (segments and decimal point)
//   seg    segments a..g on seg[0]..seg[6]
//   dp     decimal point
//   an     digit select; one-hot or none
module seg7_scan_ctrl #(
   parameter int NUM_DIGITS     = 8,
   parameter int CLK_DIV        = 100000,
   parameter int GUARD          = 2,
   parameter int SEG_ACTIVE_LOW = 0,
   parameter int AN_ACTIVE_LOW  = 1
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    en,
   input  logic [4*NUM_DIGITS-1:0] data,
   input  logic [NUM_DIGITS-1:0]   dp_in,
   input  logic [NUM_DIGITS-1:0]   blank,
   output logic [6:0]              seg,
   output logic                    dp,
   output logic [NUM_DIGITS-1:0]   an
);

   localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

   // XOR masks that turn an active-high output vector into pin polarity.
   localparam logic [6:0]            SEG_POL = (SEG_ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
   localparam logic                  DP_POL  = (SEG_ACTIVE_LOW != 0);
   localparam logic [NUM_DIGITS-1:0] AN_POL  = (AN_ACTIVE_LOW != 0) ? '1 : '0;

   logic [CW-1:0]           div_cnt;
   logic [IW-1:0]           idx;
   logic [4*NUM_DIGITS-1:0] sh_data;
   logic [NUM_DIGITS-1:0]   sh_dp;
   logic [NUM_DIGITS-1:0]   sh_blank;
   logic                    load_pend;   // shadows still need their first load

   logic                    slot_wrap;
   logic                    frame_wrap;
   logic [3:0]              cur_nib;
   logic                    cur_dp;
   logic                    cur_blank;
   logic [NUM_DIGITS-1:0]   cur_sel;
   logic                    lit;
   logic [6:0]              seg_hex;
   logic [6:0]              seg_next;
   logic                    dp_next;
   logic [NUM_DIGITS-1:0]   an_next;

   assign slot_wrap  = (div_cnt == CW'(CLK_DIV - 1));
   assign frame_wrap = slot_wrap && (idx == IW'(NUM_DIGITS - 1));

   // Select the current digit by comparing idx with each digit number.
   // Comparing against each constant keeps every select in range, whatever
   // the value of NUM_DIGITS.
   always_comb begin
      cur_nib   = 4'h0;
      cur_dp    = 1'b0;
      cur_blank = 1'b1;
      cur_sel   = '0;
      for (int k = 0; k < NUM_DIGITS; k++) begin
         if (idx == IW'(k)) begin
            cur_nib    = sh_data[k*4 +: 4];
            cur_dp     = sh_dp[k];
            cur_blank  = sh_blank[k];
            cur_sel[k] = 1'b1;
         end
      end
   end

   always_comb begin
      seg_hex = 7'h00;
      unique case (cur_nib)
         4'h0: seg_hex = 7'h3F;
         4'h1: seg_hex = 7'h06;
         4'h2: seg_hex = 7'h5B;
         4'h3: seg_hex = 7'h4F;
         4'h4: seg_hex = 7'h66;
         4'h5: seg_hex = 7'h6D;
         4'h6: seg_hex = 7'h7D;
         4'h7: seg_hex = 7'h07;
         4'h8: seg_hex = 7'h7F;
         4'h9: seg_hex = 7'h6F;
         4'hA: seg_hex = 7'h77;
         4'hB: seg_hex = 7'h7C;
         4'hC: seg_hex = 7'h39;
         4'hD: seg_hex = 7'h5E;
         4'hE: seg_hex = 7'h79;
         4'hF: seg_hex = 7'h71;
         default: seg_hex = 7'h00;
      endcase
   end

   // en gates only the anodes. While the scan is frozen, the segment lines
   // keep showing the frozen digit, but with no anode selected it stays dark.
   always_comb begin
      lit      = !cur_blank && (div_cnt >= CW'(GUARD));
      seg_next = lit ? seg_hex : 7'h00;
      dp_next  = lit && cur_dp;
      an_next  = (lit && en) ? cur_sel : '0;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         div_cnt   <= '0;
         idx       <= '0;
         sh_data   <= '0;
         sh_dp     <= '0;
         sh_blank  <= '0;
         load_pend <= 1'b1;
         seg       <= SEG_POL;
         dp        <= DP_POL;
         an        <= AN_POL;
      end else begin
         seg <= seg_next ^ SEG_POL;
         dp  <= dp_next ^ DP_POL;
         an  <= an_next ^ AN_POL;
         if (en) begin
            load_pend <= 1'b0;
            if (load_pend || frame_wrap) begin
               sh_data  <= data;
               sh_dp    <= dp_in;
               sh_blank <= blank;
            end
            if (slot_wrap) begin
               div_cnt <= '0;
               idx     <= frame_wrap ? '0 : idx + IW'(1);
            end else begin
               div_cnt <= div_cnt + CW'(1);
            end
         end
      end
   end

endmodule
